// File: rtl/caches_pkg.sv
// Shared word, RAM status and arbiter state types for the cache/memory path.
// Arbiter build option: ARB_ROUND_ROBIN_EN (round-robin tie break).
package caches_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arbstate_t;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signals of the cache memory arbiter.
// master: arbiter view, slave: caches plus RAM view.
interface cache_mem_arbiter_if;
    import caches_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      ierr;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      derr;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, ierr, dwait, dload, derr,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, ierr, dwait, dload, derr,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache requests onto a single RAM port with error retry.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of dcache priority.
module cache_mem_arbiter
    import caches_pkg::*;
#(
    parameter int unsigned ERR_RETRY_MAX = 3
) (
    input logic                 CLK,
    input logic                 nRST,
    cache_mem_arbiter_if.master bus
);
    localparam logic [1:0] RETRY_LIM = 2'(ERR_RETRY_MAX);

    arbstate_t  state_q, state_d;
    logic [1:0] retry_q, retry_d;
    logic       dreq;
    logic       dwin;
    logic       greq;
    logic       abort;
    logic       done;
    logic       gwait;

    assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_ROUND_ROBIN_EN
    logic lgnt_q, lgnt_d;

    // lgnt_q high: dcache held the most recent grant
    assign dwin = dreq & ~(bus.iREN & lgnt_q);
`else
    assign dwin = dreq;
`endif

    assign greq  = (state_q == DGNT) ? dreq : bus.iREN;
    assign abort = greq & (retry_q == RETRY_LIM);
    assign done  = greq & ~abort & (bus.ramstate == ACCESS);
    assign gwait = ~(abort | done);

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = dreq;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ierr     = 1'b0;
        bus.derr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dwin) begin
                    state_d = DGNT;
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = ~abort;
                bus.iwait   = gwait;
                bus.ierr    = abort;
                bus.iload   = done ? bus.ramload : '0;
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN & ~abort;
                bus.ramREN   = bus.dREN & ~bus.dWEN & ~abort;
                bus.dwait    = gwait;
                bus.derr     = abort;
                bus.dload    = done ? bus.ramload : '0;
            end
            default: state_d = IDLE;
        endcase
        // a dropped request leaves quietly, ahead of abort or completion
        if (state_q != IDLE) begin
            if (!greq || abort || done) begin
                state_d = IDLE;
            end else if (bus.ramstate == ERROR) begin
                retry_d = retry_q + 2'd1;
            end
        end
        if (state_d == IDLE) begin
            retry_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        lgnt_d = lgnt_q;
        if (state_q == IDLE && state_d != IDLE) begin
            lgnt_d = (state_d == DGNT);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lgnt_q <= 1'b0;
        end else begin
            lgnt_q <= lgnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised self-checking bench for cache_mem_arbiter against a
// transaction-owner reference model; honours ARB_ROUND_ROBIN_EN.
module tb_cache_mem_arbiter;
    import caches_pkg::*;

    localparam int MAXR = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(
        .ERR_RETRY_MAX(MAXR)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: own 0 = nobody, 1 = icache, 2 = dcache
    int own = 0;
    int errs = 0;
    bit last_d = 1'b0;
    int n_own;
    int n_errs;
    bit n_last;

    logic  e_rren, e_rwen, e_iw, e_dw, e_ie, e_de;
    word_t e_addr, e_store, e_il, e_dl;

    int    rren_cnt, derr_cnt, dload_nz, dwait_lo;
    bit    got_first;
    word_t first_addr;
    word_t last_iload;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic eval();
        logic dq;
        logic rq;
        dq      = bus.dREN | bus.dWEN;
        e_rren  = 1'b0;
        e_rwen  = 1'b0;
        e_addr  = '0;
        e_store = '0;
        e_iw    = bus.iREN;
        e_dw    = dq;
        e_il    = '0;
        e_dl    = '0;
        e_ie    = 1'b0;
        e_de    = 1'b0;
        n_own   = own;
        n_errs  = errs;
        n_last  = last_d;
        if (own == 0) begin
            if (dq && !(RR && bus.iREN && last_d)) begin
                n_own  = 2;
                n_last = 1'b1;
            end else if (bus.iREN) begin
                n_own  = 1;
                n_last = 1'b0;
            end
        end else begin
            rq = (own == 2) ? dq : bus.iREN;
            if (own == 1) begin
                e_addr = bus.iaddr;
                e_rren = 1'b1;
                e_iw   = 1'b1;
            end else begin
                e_addr  = bus.daddr;
                e_store = bus.dstore;
                e_rwen  = bus.dWEN;
                e_rren  = bus.dREN & ~bus.dWEN;
                e_dw    = 1'b1;
            end
            if (!rq) begin
                n_own = 0;
            end else if (errs == MAXR) begin
                e_rren = 1'b0;
                e_rwen = 1'b0;
                n_own  = 0;
                if (own == 1) begin
                    e_iw = 1'b0;
                    e_ie = 1'b1;
                end else begin
                    e_dw = 1'b0;
                    e_de = 1'b1;
                end
            end else if (bus.ramstate == ACCESS) begin
                n_own = 0;
                if (own == 1) begin
                    e_iw = 1'b0;
                    e_il = bus.ramload;
                end else begin
                    e_dw = 1'b0;
                    e_dl = bus.ramload;
                end
            end else if (bus.ramstate == ERROR) begin
                n_errs = errs + 1;
            end
            if (n_own == 0) n_errs = 0;
        end
    endtask

    task automatic check_all();
        chk("ramREN",   32'(bus.ramREN), 32'(e_rren));
        chk("ramWEN",   32'(bus.ramWEN), 32'(e_rwen));
        chk("ramaddr",  bus.ramaddr,     e_addr);
        chk("ramstore", bus.ramstore,    e_store);
        chk("iwait",    32'(bus.iwait),  32'(e_iw));
        chk("dwait",    32'(bus.dwait),  32'(e_dw));
        chk("iload",    bus.iload,       e_il);
        chk("dload",    bus.dload,       e_dl);
        chk("ierr",     32'(bus.ierr),   32'(e_ie));
        chk("derr",     32'(bus.derr),   32'(e_de));
        if (bus.ramREN) rren_cnt++;
        if (bus.derr) derr_cnt++;
        if (bus.dload != '0) dload_nz++;
        if (!bus.dwait) dwait_lo++;
        if (!bus.iwait && bus.iREN) last_iload = bus.iload;
        if (!got_first && (bus.ramREN || bus.ramWEN)) begin
            got_first  = 1'b1;
            first_addr = bus.ramaddr;
        end
    endtask

    // caller is at a falling edge with inputs already applied
    task automatic tick();
        #1;
        eval();
        check_all();
        @(posedge CLK);
        #1;
        own    = n_own;
        errs   = n_errs;
        last_d = n_last;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST   = 1'b0;
        own    = 0;
        errs   = 0;
        last_d = 1'b0;
        #1;
        eval();
        check_all();
        @(posedge CLK);
        #1;
        cyc++;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic clr_mon();
        rren_cnt  = 0;
        derr_cnt  = 0;
        dload_nz  = 0;
        dwait_lo  = 0;
        got_first = 1'b0;
        first_addr = '0;
        last_iload = '0;
    endtask

    initial begin
        int r;
        nRST         = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
        clr_mon();
        @(negedge CLK);
        do_reset();

        // icache read, two BUSY then ACCESS
        clr_mon();
        bus.iREN = 1'b1;
        bus.iaddr = 32'h100;
        bus.ramstate = BUSY;
        tick();
        tick();
        tick();
        bus.ramstate = ACCESS;
        bus.ramload = 32'hDEADBEEF;
        tick();
        bus.iREN = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("ireq_ren_cycles", 32'(rren_cnt), 32'd3);
        chk("ireq_iload", last_iload, 32'hDEADBEEF);

        // dcache read leaves dcache as last grant
        bus.dREN = 1'b1;
        bus.daddr = 32'h80;
        bus.ramstate = ACCESS;
        bus.ramload = 32'h0BADF00D;
        tick();
        tick();
        bus.dREN = 1'b0;
        bus.ramstate = BUSY;
        tick();

        // simultaneous icache read and dcache write
        clr_mon();
        bus.iREN = 1'b1;
        bus.iaddr = 32'h300;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h200;
        bus.dstore = 32'h12345678;
        tick();
        bus.ramstate = ACCESS;
        tick();
        if (RR) bus.iREN = 1'b0;
        else bus.dWEN = 1'b0;
        tick();
        tick();
        bus.iREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("tie_first", first_addr, RR ? 32'h300 : 32'h200);

        // three consecutive errors abandon the dcache read
        clr_mon();
        bus.dREN = 1'b1;
        bus.daddr = 32'h40;
        bus.ramstate = ERROR;
        for (int i = 0; i < 5; i++) tick();
        bus.dREN = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("err_derr_pulses", 32'(derr_cnt), 32'd1);
        chk("err_dload", 32'(dload_nz), 32'd0);

        // reset in the middle of a busy dcache grant
        clr_mon();
        bus.dREN = 1'b1;
        bus.daddr = 32'h44;
        bus.ramstate = BUSY;
        tick();
        tick();
        bus.dREN = 1'b0;
        do_reset();
        bus.iREN = 1'b1;
        bus.iaddr = 32'h104;
        bus.ramstate = ACCESS;
        bus.ramload = 32'h55;
        tick();
        tick();
        bus.iREN = 1'b0;
        tick();
        chk("rst_derr", 32'(derr_cnt), 32'd0);
        chk("rst_after_iload", last_iload, 32'h55);

        // dcache drops its request while BUSY
        clr_mon();
        bus.dREN = 1'b1;
        bus.daddr = 32'h48;
        bus.ramstate = BUSY;
        tick();
        tick();
        bus.dREN = 1'b0;
        tick();
        chk("drop_dwait_low", 32'(dwait_lo), 32'd0);
        tick();
        chk("drop_derr", 32'(derr_cnt), 32'd0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(0, 7) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(0, 15) == 0) bus.dWEN = ~bus.dWEN;
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            r = int'($urandom_range(0, 9));
            if (r < 4) bus.ramstate = BUSY;
            else if (r < 7) bus.ramstate = ACCESS;
            else if (r < 9) bus.ramstate = ERROR;
            else bus.ramstate = FREE;
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
